// File: rtl/calc_sequencer_s7.sv
// calc_sequencer_s7
// Control FSM for the S7 calculator. Steps the user through operand 1 entry,
// operand 2 entry, operation select, ALU execute and result display. It also
// owns the operand/opcode/result registers that feed the ALU and display mux.
//
// Parameters:
//   N        operand/result width
//   TIMEOUT  maximum number of EXEC cycles spent waiting for alu_done (>= 2)
//
// Ports:
//   clk         in   system clock, rising edge
//   resetN      in   asynchronous active-low reset
//   enter       in   debounced button level (rising edge detected here)
//   undo        in   debounced button level (rising edge detected here)
//   data_in     in   N-bit switch value for operand entry
//   op_in       in   2-bit switch value for operation select
//   alu_result  in   N-bit ALU output
//   alu_done    in   ALU completion level, sampled every EXEC cycle
//   state       out  current state, doubles as display-mux select
//   op1, op2    out  operand registers
//   op_code     out  registered operation select
//   alu_start   out  one-cycle start pulse, high in the first EXEC cycle
//   result      out  captured ALU result (all ones after a timeout)
//   err         out  sticky timeout flag
//   busy        out  high while in EXEC
module calc_sequencer_s7 #(
    parameter int N       = 16,
    parameter int TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         enter,
    input  logic         undo,
    input  logic [N-1:0] data_in,
    input  logic [1:0]   op_in,
    input  logic [N-1:0] alu_result,
    input  logic         alu_done,
    output logic [3:0]   state,
    output logic [N-1:0] op1,
    output logic [N-1:0] op2,
    output logic [1:0]   op_code,
    output logic         alu_start,
    output logic [N-1:0] result,
    output logic         err,
    output logic         busy
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    // State values are the display-mux encoding, so the register is exported as is.
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ERR   = 4'd3,
        S_OP1   = 4'd4,
        S_OP2   = 4'd8,
        S_OPSEL = 4'd9,
        S_EXEC  = 4'd10,
        S_SHOW  = 4'd11
    } state_t;

    state_t          cur_state;
    state_t          nxt_state;
    logic            enter_q;
    logic            undo_q;
    logic            enter_e;
    logic            undo_e;
    logic [CW-1:0]   cnt;
    logic            start_exec;
    logic            take_result;
    logic            take_timeout;
    logic            clear_err;

    // enter wins over undo when both rise in the same cycle.
    assign enter_e = enter & ~enter_q;
    assign undo_e  = undo & ~undo_q & ~enter_e;

    assign state = cur_state;
    assign busy  = (cur_state == S_EXEC);

    // State register and button history.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cur_state <= S_IDLE;
            enter_q   <= 1'b0;
            undo_q    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            enter_q   <= enter;
            undo_q    <= undo;
        end
    end

    // Next-state logic plus the one-shot strobes the datapath acts on.
    // In EXEC the first cycle (cnt == 0) is the start cycle, so alu_done is
    // not trusted there; alu_done beats the timeout when both coincide.
    always_comb begin
        nxt_state    = cur_state;
        start_exec   = 1'b0;
        take_result  = 1'b0;
        take_timeout = 1'b0;
        clear_err    = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (enter_e) nxt_state = S_OP1;
            end
            S_OP1: begin
                if (enter_e) nxt_state = S_OP2;
            end
            S_OP2: begin
                if (enter_e)     nxt_state = S_OPSEL;
                else if (undo_e) nxt_state = S_OP1;
            end
            S_OPSEL: begin
                if (enter_e) begin
                    nxt_state  = S_EXEC;
                    start_exec = 1'b1;
                end else if (undo_e) begin
                    nxt_state = S_OP2;
                end
            end
            S_EXEC: begin
                if ((cnt != CW'(0)) && alu_done) begin
                    nxt_state   = S_SHOW;
                    take_result = 1'b1;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    nxt_state    = S_ERR;
                    take_timeout = 1'b1;
                end
            end
            S_SHOW: begin
                if (enter_e)     nxt_state = S_OP1;
                else if (undo_e) nxt_state = S_OPSEL;
            end
            S_ERR: begin
                if (enter_e) begin
                    nxt_state = S_OP1;
                    clear_err = 1'b1;
                end
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    // Datapath registers. Entry states load continuously so the value sampled
    // on the confirming enter edge is the one kept.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            op1       <= '0;
            op2       <= '0;
            op_code   <= 2'b00;
            result    <= '0;
            err       <= 1'b0;
            alu_start <= 1'b0;
            cnt       <= '0;
        end else begin
            alu_start <= start_exec;
            if (cur_state == S_OP1)   op1     <= data_in;
            if (cur_state == S_OP2)   op2     <= data_in;
            if (cur_state == S_OPSEL) op_code <= op_in;
            if (start_exec)                 cnt <= '0;
            else if (cur_state == S_EXEC)   cnt <= cnt + CW'(1);
            if (take_result) begin
                result <= alu_result;
            end else if (take_timeout) begin
                result <= {N{1'b1}};
                err    <= 1'b1;
            end
            if (clear_err) err <= 1'b0;
        end
    end

endmodule

// File: doc/calc_sequencer_s7.md
# calc_sequencer_s7

Control FSM for the S7 calculator. It walks the user through operand 1 entry, operand 2 entry, operation select, ALU execute and result display. It holds the OP1/OP2/opcode/result registers that feed the ALU and the display mux. Its 4-bit `state` output drives the display multiplexer directly, using the display encoding below: 0–3 show result, 4–7 show OP1, 8–9 show OP2, 10–11 show result.

## Interface
- `N`, 16, operand/result width
- `TIMEOUT`, 8, max cycles in EXEC waiting for `alu_done` (≥2)
- `clk`  in  1  system clock, rising edge
- `resetN`  in  1  asynchronous, active-low reset
- `enter`  in  1  debounced button level; block detects rising edge internally
- `undo`  in  1  debounced button level; rising edge detected internally
- `data_in`  in  N  switch value for operand entry
- `op_in`  in  2  switch value for operation select
- `alu_result`  in  N  ALU output
- `alu_done`  in  1  ALU completion, level, sampled each EXEC cycle
- `state`  out  4  current FSM state (display encoding)
- `op1`, `op2`  out  N  operand registers to ALU/display
- `op_code`  out  2  registered operation select
- `alu_start`  out  1  one-cycle start pulse
- `result`  out  N  captured ALU result
- `err`  out  1  sticky timeout flag
- `busy`  out  1  high while state == EXEC

## Operation
- Edge detect:
  - `enter_q` and `undo_q` are registered copies of the inputs.
  - `enter_e = enter & ~enter_q`; `undo_e = undo & ~undo_q`.
  - `enter_e` has priority: if both edges occur in the same cycle, `undo_e` is ignored.
- States (value: name):
  - 0: IDLE. Holds.
    - `enter_e` → OP1.
  - 4: OP1. `op1 <= data_in` every cycle.
    - `enter_e` → OP2.
  - 8: OP2. `op2 <= data_in` every cycle.
    - `enter_e` → OPSEL; `undo_e` → OP1.
  - 9: OPSEL. `op_code <= op_in` every cycle.
    - `enter_e` → EXEC; `undo_e` → OP2.
  - 10: EXEC. Button edges are ignored.
    - `alu_done` → SHOW, with `result <= alu_result`.
    - Timeout → ERR, with `result <= {N{1'b1}}` and `err <= 1`.
  - 11: SHOW. Holds.
    - `enter_e` → OP1 (new calculation; `op1`/`op2` keep their values until overwritten).
    - `undo_e` → OPSEL (re-select the operation and re-execute).
  - 3: ERR. Holds.
    - `enter_e` → OP1, with `err <= 0`.
- Values 1, 2, 5, 6, 7 are unreachable. An illegal state recovers to IDLE on the next clock without touching the data registers.
- `err` clears only on ERR→OP1 or on reset.

## Timing
- Reset (async, `resetN` = 0): `state` = 0, `op1` = `op2` = `result` = 0, `op_code` = 0, `alu_start` = 0, `err` = 0, `busy` = 0, `enter_q` = `undo_q` = 0.
- Reset asserted mid-EXEC aborts immediately. No `alu_start` follows release.
- Button edge to state change is one clock: the rising `enter` is sampled at edge k and `state` updates at edge k+1. Holding a button produces exactly one transition.
- All register loads in OP1/OP2/OPSEL are registered, so `op1` reflects the `data_in` value sampled one clock earlier.
- The OP1 load on the cycle that sees `enter_e` still occurs, so the last sampled value is kept.
- `alu_start` is registered:
  - It is high during the first EXEC cycle only.
  - `op1`, `op2` and `op_code` are stable throughout EXEC.
- Timeout counter:
  - Clears on EXEC entry and increments each EXEC cycle.
  - `alu_done` is ignored in the first EXEC cycle (the start cycle).
  - If `alu_done` is not seen by counter value `TIMEOUT-1`, the next state is ERR.
  - If `alu_done` and timeout occur in the same cycle, `alu_done` wins.
- `result` updates on the same edge that enters SHOW/ERR and is otherwise held.
- `busy` is combinational from `state`.

## Test plan
- Reset then idle: `resetN` low → all outputs 0, `state` = 0. Release, press `enter` → `state` = 4 one clock after the edge.
- Full calc: `data_in` = 0x0012, `enter` → `op1` = 0x0012, `state` = 8. Then `data_in` = 0x0034, `enter`; `op_in` = 2'b01, `enter`. Expect `alu_start` high for exactly 1 cycle with `state` = 10. ALU model asserts `alu_done` 3 cycles later with `alu_result` = 0x0046 → `state` = 11, `result` = 0x0046, `busy` = 0.
- Undo path: in OPSEL press `undo` → `state` = 8. Press `undo` again → `state` = 4. `enter` and `undo` rising together in OP2 → `state` = 9 (`undo` ignored).
- Held button: `enter` held high 20 cycles in OP1 → single transition to 8, no further advance.
- Timeout: TIMEOUT = 8, ALU never responds → `state` = 3, `result` = 0xFFFF, `err` = 1. `enter` → `state` = 4, `err` = 0. Also `alu_done` arriving exactly at count 7 → SHOW, `err` = 0.
- Reset mid-EXEC: drop `resetN` 2 cycles into EXEC → immediate `state` = 0, registers 0. After release no `alu_start` pulse occurs.
